// File: rtl/nrisc_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : nrisc_prog_loader
//  Purpose  : Byte-stream program/data loader for the nRisc 8-bit core.
//             Accepts framed bytes (SYNC, CMD, ADDR, LEN, payload, CHK) over a
//             valid/ready stream, writes instruction or data memory as the
//             payload streams in, and holds the core in reset until a RUN
//             frame (SYNC, 8'h03) is received.
//  Ports    : CLK        - system clock, rising edge
//             reset      - asynchronous active-low reset
//             in_valid   - stream byte valid
//             in_data    - stream byte
//             in_ready   - loader accepts a byte this cycle
//             imem_we    - instruction-memory write strobe
//             dmem_we    - data-memory write strobe
//             mem_addr   - shared write address
//             mem_wdata  - write data
//             cpu_hold   - 1 holds the core in reset
//             done       - RUN accepted, cleared by next SYNC
//             err        - sticky frame error, cleared by next SYNC
//  Revision : 1.0  initial release
// ============================================================================
module nrisc_prog_loader #(
  parameter int              ADDR_W    = 8,
  parameter int              DATA_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [DATA_W-1:0] c_cmd_imem = 8'h01;
  localparam logic [DATA_W-1:0] c_cmd_dmem = 8'h02;
  localparam logic [DATA_W-1:0] c_cmd_run  = 8'h03;

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_LEN  = 3'd3,
    S_DATA = 3'd4,
    S_CHK  = 3'd5,
    S_RUN  = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_xfer;
  logic                w_is_sync;

  logic                r_in_ready;
  logic                r_imem_we;
  logic                r_dmem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_cpu_hold;
  logic                r_done;
  logic                r_err;
  logic [DATA_W-1:0]   r_chk;
  logic [DATA_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_tgt_imem;

  assign w_xfer    = in_valid & r_in_ready;
  assign w_is_sync = (in_data == SYNC_BYTE);

  // Next-state logic; every state except ERR only moves on an accepted byte.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HUNT, S_RUN: begin
        if (w_xfer && w_is_sync) w_state_next = S_CMD;
      end
      S_CMD: begin
        if (w_xfer) begin
          if (in_data == c_cmd_imem || in_data == c_cmd_dmem) w_state_next = S_ADDR;
          else if (in_data == c_cmd_run)                      w_state_next = S_RUN;
          else                                                w_state_next = S_ERR;
        end
      end
      S_ADDR: begin
        if (w_xfer) w_state_next = S_LEN;
      end
      S_LEN: begin
        if (w_xfer) w_state_next = (in_data == '0) ? S_ERR : S_DATA;
      end
      S_DATA: begin
        if (w_xfer && r_cnt == 8'd1) w_state_next = S_CHK;
      end
      S_CHK: begin
        if (w_xfer) w_state_next = (in_data == r_chk) ? S_HUNT : S_ERR;
      end
      S_ERR:   w_state_next = S_HUNT;
      default: w_state_next = S_HUNT;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_in_ready  <= 1'b0;
      r_imem_we   <= 1'b0;
      r_dmem_we   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_chk       <= '0;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_tgt_imem  <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses; ready drops only for the ERR cycle.
      r_imem_we  <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_in_ready <= (w_state_next != S_ERR);

      if (w_xfer) begin
        case (r_state)
          S_HUNT, S_RUN: begin
            if (w_is_sync) begin
              r_cpu_hold <= 1'b1;
              r_done     <= 1'b0;
              r_err      <= 1'b0;
              r_chk      <= '0;
            end
          end
          S_CMD: begin
            // chk was cleared on SYNC, so the command byte seeds it.
            r_chk      <= in_data;
            r_tgt_imem <= (in_data == c_cmd_imem);
            if (in_data == c_cmd_run) begin
              r_cpu_hold <= 1'b0;
              r_done     <= 1'b1;
            end
          end
          S_ADDR: begin
            r_ptr <= ADDR_W'(in_data);
            r_chk <= r_chk ^ in_data;
          end
          S_LEN: begin
            r_cnt <= in_data;
            r_chk <= r_chk ^ in_data;
          end
          S_DATA: begin
            r_chk       <= r_chk ^ in_data;
            r_cnt       <= r_cnt - 8'd1;
            r_imem_we   <= r_tgt_imem;
            r_dmem_we   <= ~r_tgt_imem;
            r_mem_addr  <= r_ptr;
            r_mem_wdata <= in_data;
            // Wraps modulo 2^ADDR_W by construction.
            r_ptr       <= r_ptr + ADDR_W'(1);
          end
          default: ;
        endcase
      end

      if (w_state_next == S_ERR) r_err <= 1'b1;
    end
  end

  assign in_ready  = r_in_ready;
  assign imem_we   = r_imem_we;
  assign dmem_we   = r_dmem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_nrisc_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nrisc_prog_loader
//  Purpose  : Self-checking bench for nrisc_prog_loader: table of stream
//             bytes with expected registered outputs, plus hand-written
//             reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nrisc_prog_loader;

  logic       CLK;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       imem_we;
  logic       dmem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  nrisc_prog_loader #(
    .ADDR_W    (8),
    .DATA_W    (8),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .dmem_we   (dmem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {in_ready, imem_we, dmem_we, cpu_hold, done, err, mem_addr, mem_wdata}
  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [21:0] mk(input logic rdy, input logic iwe, input logic dwe,
                                     input logic hold, input logic dn, input logic er,
                                     input logic [7:0] a, input logic [7:0] wd);
    return {rdy, iwe, dwe, hold, dn, er, a, wd};
  endfunction

  task automatic add(input logic v, input logic [7:0] d, input logic rdy, input logic iwe,
                     input logic dwe, input logic hold, input logic dn, input logic er,
                     input logic [7:0] a, input logic [7:0] wd);
    vec_t r;
    r.v   = v;
    r.d   = d;
    r.exp = mk(rdy, iwe, dwe, hold, dn, er, a, wd);
    tbl.push_back(r);
  endtask

  function automatic logic [21:0] actual();
    return {in_ready, imem_we, dmem_we, cpu_hold, done, err, mem_addr, mem_wdata};
  endfunction

  // Address/data are only meaningful while a strobe is expected.
  task automatic compare(input string name, input logic [21:0] exp, input logic full);
    logic [21:0] mask;
    logic [21:0] act;
    mask = (full || exp[20] || exp[19]) ? 22'h3FFFFF : 22'h3F0000;
    act  = actual();
    n_checks++;
    if ((act & mask) !== (exp & mask)) begin
      n_errors++;
      $display("FAIL %s: got rdy/iwe/dwe/hold/done/err=%b addr=%h data=%h, want %b addr=%h data=%h",
               name, act[21:16], act[15:8], act[7:0], exp[21:16], exp[15:8], exp[7:0]);
    end
  endtask

  // Present a byte, clock it, and check the registered result of that edge.
  task automatic step(input logic v, input logic [7:0] d, input string name,
                      input logic [21:0] exp);
    in_valid = v;
    in_data  = d;
    @(posedge CLK);
    #1;
    compare(name, exp, 1'b0);
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset held for two cycles.
    repeat (2) @(posedge CLK);
    #1;
    compare("reset_values", mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h00), 1'b1);
    reset = 1'b1;

    //  v  d      rdy iwe dwe hold done err addr   wdata
    add(0, 8'h00, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);  // ready rises after release
    // IMEM load 10..12 = 11,22,33; chk = 01^10^03^11^22^33 = 12
    add(1, 8'hA5, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'h01, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'h10, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'h03, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'h11, 1,  1,  0,  1,   0,   0,  8'h10, 8'h11);
    add(1, 8'h22, 1,  1,  0,  1,   0,   0,  8'h11, 8'h22);
    add(1, 8'h33, 1,  1,  0,  1,   0,   0,  8'h12, 8'h33);
    add(1, 8'h12, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    // RUN, idle, then SYNC re-asserts hold
    add(1, 8'hA5, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'h03, 1,  0,  0,  0,   1,   0,  8'h00, 8'h00);
    add(0, 8'h00, 1,  0,  0,  0,   1,   0,  8'h00, 8'h00);
    add(1, 8'hA5, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    // Bad checksum DMEM frame (SYNC already taken above)
    add(1, 8'h02, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'h00, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'h01, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'h7F, 1,  0,  1,  1,   0,   0,  8'h00, 8'h7F);
    add(1, 8'h00, 0,  0,  0,  1,   0,   1,  8'h00, 8'h00);  // ERR cycle
    add(1, 8'hA5, 1,  0,  0,  1,   0,   1,  8'h00, 8'h00);  // dropped: not ready
    add(1, 8'hA5, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'h03, 1,  0,  0,  0,   1,   0,  8'h00, 8'h00);
    // Wrap with gaps; chk = 02^FF^02^AA^BB = EE
    add(1, 8'hA5, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(0, 8'h02, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'h02, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(0, 8'h55, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'hFF, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'h02, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(0, 8'hAA, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'hAA, 1,  0,  1,  1,   0,   0,  8'hFF, 8'hAA);
    add(0, 8'hBB, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'hBB, 1,  0,  1,  1,   0,   0,  8'h00, 8'hBB);
    add(0, 8'hEE, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'hEE, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    // Garbage in HUNT, illegal CMD, zero LEN
    add(1, 8'h3C, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'h03, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);  // 03 outside a frame: ignored
    add(1, 8'hA5, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'h07, 0,  0,  0,  1,   0,   1,  8'h00, 8'h00);
    add(0, 8'h00, 1,  0,  0,  1,   0,   1,  8'h00, 8'h00);
    add(1, 8'hA5, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'h01, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'h20, 1,  0,  0,  1,   0,   0,  8'h00, 8'h00);
    add(1, 8'h00, 0,  0,  0,  1,   0,   1,  8'h00, 8'h00);
    add(0, 8'h00, 1,  0,  0,  1,   0,   1,  8'h00, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, $sformatf("vec%0d", i), tbl[i].exp);
    end

    // Reset asserted during DATA: strobes stop immediately.
    step(1, 8'hA5, "mr_sync", mk(1, 0, 0, 1, 0, 0, 8'h00, 8'h00));
    step(1, 8'h01, "mr_cmd",  mk(1, 0, 0, 1, 0, 0, 8'h00, 8'h00));
    step(1, 8'h40, "mr_addr", mk(1, 0, 0, 1, 0, 0, 8'h00, 8'h00));
    step(1, 8'h04, "mr_len",  mk(1, 0, 0, 1, 0, 0, 8'h00, 8'h00));
    step(1, 8'h11, "mr_d0",   mk(1, 1, 0, 1, 0, 0, 8'h40, 8'h11));
    step(1, 8'h22, "mr_d1",   mk(1, 1, 0, 1, 0, 0, 8'h41, 8'h22));
    reset = 1'b0;
    #1;
    compare("mr_async_reset", mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h00), 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h33;
    @(posedge CLK);
    #1;
    compare("mr_held_in_reset", mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h00), 1'b1);
    reset    = 1'b1;
    in_valid = 1'b0;
    step(0, 8'h00, "mr_ready_back", mk(1, 0, 0, 1, 0, 0, 8'h00, 8'h00));
    step(1, 8'h33, "mr_no_resume",  mk(1, 0, 0, 1, 0, 0, 8'h00, 8'h00));
    step(1, 8'hA5, "mr_sync2",      mk(1, 0, 0, 1, 0, 0, 8'h00, 8'h00));
    step(1, 8'h03, "mr_run",        mk(1, 0, 0, 0, 1, 0, 8'h00, 8'h00));
    step(0, 8'h00, "mr_idle",       mk(1, 0, 0, 0, 1, 0, 8'h00, 8'h00));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Strobes must never both be high.
  always @(negedge CLK) begin
    if (reset && imem_we && dmem_we) begin
      n_errors++;
      $display("FAIL both_strobes: imem_we=%b dmem_we=%b, want at most one high", imem_we, dmem_we);
    end
  end

endmodule
`default_nettype wire
